// File: rtl/des_pkg.sv
// Shared constants, tables and helpers for the DES key schedule.
// Bit ordering: vector bit i carries FIPS bit i+1 (C = bits 27:0, D = bits 55:28).
package des_pkg;

   localparam int KEY_W    = 56;
   localparam int SUBKEY_W = 48;
   localparam int HALF_W   = 28;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Entry j names the FIPS CD bit (1-based) that feeds subkey bit j.
   localparam int PC2_TABLE [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // A FIPS left rotate moves bit 1 to the end, i.e. a vector shift toward bit 0.
   function automatic logic [HALF_W-1:0] rot_left(input logic [HALF_W-1:0] h, input int n);
      return (n == 2) ? {h[1:0], h[HALF_W-1:2]} : {h[0], h[HALF_W-1:1]};
   endfunction

   function automatic logic [HALF_W-1:0] rot_right(input logic [HALF_W-1:0] h, input int n);
      return (n == 2) ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
   endfunction

endpackage

// File: rtl/permuted_choice_2.sv
// Combinational PC-2: selects 48 of the 56 C/D bits to form a round subkey.
module permuted_choice_2
   import des_pkg::*;
(
   input  logic [KEY_W-1:0]    cd,
   output logic [SUBKEY_W-1:0] subkey
);

   for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_bit
      assign subkey[gi] = cd[PC2_TABLE[gi] - 1];
   end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: streams 16 subkeys per loaded key over a valid/ready
// handshake, forward for encryption or reversed for decryption.
module des_key_schedule
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [KEY_W-1:0]    key_in,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic                decrypt,
   output logic [SUBKEY_W-1:0] subkey,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [3:0]          round_idx,
   output logic                last
);

   state_t              state_reg;
   logic [KEY_W-1:0]    cd_reg, cd_next;
   logic                decrypt_reg;
   logic [3:0]          idx_reg, idx_next;
   logic [SUBKEY_W-1:0] subkey_reg, pc2_out;
   logic                valid_reg, last_reg, last_next;
   logic                load, advance, step, finish;

   // PC-2 looks at the next C/D so the subkey register updates in the same edge.
   permuted_choice_2 u_pc2 (
      .cd     (cd_next),
      .subkey (pc2_out)
   );

   always_comb begin
      load     = (state_reg == IDLE) && key_valid;
      advance  = (state_reg == RUN) && valid_reg && subkey_ready;
      step     = advance && !last_reg;
      finish   = advance && last_reg;
      cd_next  = cd_reg;
      idx_next = idx_reg;
      if (load) begin
         if (decrypt) begin
            idx_next = 4'd15;
            cd_next  = key_in;
         end else begin
            idx_next = 4'd0;
            cd_next  = {rot_left(key_in[55:28], SHIFTS[0]), rot_left(key_in[27:0], SHIFTS[0])};
         end
      end else if (step) begin
         if (decrypt_reg) begin
            // Undo the shift that produced the current round to reach the previous one.
            idx_next = idx_reg - 4'd1;
            cd_next  = {rot_right(cd_reg[55:28], SHIFTS[idx_reg]),
                        rot_right(cd_reg[27:0], SHIFTS[idx_reg])};
         end else begin
            idx_next = idx_reg + 4'd1;
            cd_next  = {rot_left(cd_reg[55:28], SHIFTS[idx_next]),
                        rot_left(cd_reg[27:0], SHIFTS[idx_next])};
         end
      end
      last_next = (load ? decrypt : decrypt_reg) ? (idx_next == 4'd0) : (idx_next == 4'd15);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cd_reg      <= '0;
         decrypt_reg <= 1'b0;
         idx_reg     <= 4'd0;
         subkey_reg  <= '0;
         valid_reg   <= 1'b0;
         last_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (load) begin
               state_reg   <= RUN;
               decrypt_reg <= decrypt;
               valid_reg   <= 1'b1;
            end
            RUN: if (finish) begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
         if (load || step) begin
            cd_reg     <= cd_next;
            idx_reg    <= idx_next;
            subkey_reg <= pc2_out;
            last_reg   <= last_next;
         end else if (finish) begin
            last_reg <= 1'b0;
         end
      end
   end

   assign key_ready    = (state_reg == IDLE);
   assign subkey       = subkey_reg;
   assign subkey_valid = valid_reg;
   assign round_idx    = idx_reg;
   assign last         = last_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule against a table-driven DES key schedule model.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [55:0] key_in = '0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic        decrypt = 1'b0;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready = 1'b0;
   logic [3:0]  round_idx;
   logic        last;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int TB_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int TB_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int TB_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic [47:0] exp_ks [16];
   logic [47:0] first_sk, last_sk;

   des_key_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .decrypt      (decrypt),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .round_idx    (round_idx),
      .last         (last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // FIPS hex values number bit 1 as the MSB; the DUT puts bit 1 at index 0.
   function automatic logic [47:0] rev48(input logic [47:0] x);
      logic [47:0] r;
      for (int j = 0; j < 48; j++) r[j] = x[47 - j];
      return r;
   endfunction

   function automatic logic [55:0] fips_pc1(input logic [63:0] k);
      logic [55:0] r;
      for (int i = 0; i < 56; i++) r[i] = k[64 - TB_PC1[i]];
      return r;
   endfunction

   // Round r uses each half rotated left by the cumulative shift count.
   task automatic build_model(input logic [55:0] key);
      int tot = 0;
      for (int r = 0; r < 16; r++) begin
         tot += TB_SHIFT[r];
         for (int i = 0; i < 48; i++) begin
            int p = TB_PC2[i] - 1;
            if (p < 28) exp_ks[r][i] = key[(p + tot) % 28];
            else        exp_ks[r][i] = key[28 + ((p - 28 + tot) % 28)];
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_kready"}, key_ready, 1);
      check({tag, "_valid"}, subkey_valid, 0);
      check({tag, "_subkey"}, subkey, 0);
      check({tag, "_idx"}, round_idx, 0);
      check({tag, "_last"}, last, 0);
   endtask

   task automatic run_seq(input logic [55:0] key, input bit dec, input bit stall,
                          input bit pulse, input int abort_at);
      int n = 0;
      int cyc = 0;
      int w = 0;
      bit rdy;
      logic [63:0] rnd;
      build_model(key);
      while (!key_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      check("wait_kready", key_ready, 1);
      key_in = key; decrypt = dec; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      while (n < 16 && cyc < 300) begin
         int ei = dec ? 15 - n : n;
         check("valid", subkey_valid, 1);
         check("kready_run", key_ready, 0);
         check("subkey", subkey, exp_ks[ei]);
         check("round_idx", round_idx, ei);
         check("last", last, (n == 15));
         if (n == 0) first_sk = subkey;
         if (n == 15) last_sk = subkey;
         rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         subkey_ready = rdy;
         if (pulse) begin
            rnd = {$urandom(), $urandom()};
            key_in = rnd[55:0];
            key_valid = $urandom_range(0, 1) != 0;
            decrypt = ~dec;
         end
         @(posedge clk); #1;
         cyc++;
         if (rdy) n++;
         if (abort_at > 0 && n == abort_at) begin
            key_valid = 1'b0; subkey_ready = 1'b0;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("rst_mid");
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("rst_rel_valid", subkey_valid, 0);
            check("rst_rel_kready", key_ready, 1);
            return;
         end
      end
      key_valid = 1'b0;
      subkey_ready = 1'b0;
      check("seq_done", n, 16);
      check("bubble_valid", subkey_valid, 0);
      check("bubble_kready", key_ready, 1);
      $display("[TB] key %h dec=%0d stall=%0d pulse=%0d: %0d subkeys in %0d cycles",
               key, dec, stall, pulse, n, cyc);
   endtask

   initial begin
      logic [55:0] fk;
      logic [63:0] rnd;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_valid", subkey_valid, 0);

      fk = fips_pc1(64'h133457799BBCDFF1);
      run_seq(fk, 1'b0, 1'b0, 1'b0, 0);
      check("fips_k1", first_sk, rev48(48'h1B02EFFC7072));
      check("fips_k16", last_sk, rev48(48'hCB3D8B0E17F5));
      run_seq(fk, 1'b1, 1'b0, 1'b0, 0);
      check("fips_dec_first", first_sk, rev48(48'hCB3D8B0E17F5));
      check("fips_dec_last", last_sk, rev48(48'h1B02EFFC7072));

      run_seq(fk, 1'b0, 1'b1, 1'b0, 0);
      for (int t = 0; t < 6; t++) begin
         rnd = {$urandom(), $urandom()};
         run_seq(rnd[55:0], t[0], 1'b1, 1'b0, 0);
      end
      for (int t = 0; t < 3; t++) begin
         rnd = {$urandom(), $urandom()};
         run_seq(rnd[55:0], t[0], 1'b1, 1'b1, 0);
      end

      run_seq(fk, 1'b0, 1'b0, 1'b0, 7);
      run_seq(fk, 1'b0, 1'b0, 1'b0, 0);
      check("after_rst_k1", first_sk, rev48(48'h1B02EFFC7072));

      run_seq('0, 1'b0, 1'b0, 1'b0, 0);
      check("zero_k1", first_sk, 48'h0);
      run_seq('1, 1'b1, 1'b1, 1'b0, 0);
      check("ones_k16", first_sk, 48'hFFFFFFFFFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
